// File: rtl/ctrl_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_defs_pkg : opcode/funct/ALU constants and control-bundle layout  |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package ctrl_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_RT   = 2'd1,
    WR_RD   = 2'd2,
    WR_R31  = 2'd3
  } wr_sel_e;

  // Field order of the single-bit part of the ID/EX control bundle
  typedef struct packed {
    logic valid;
    logic regw;
    logic memr;
    logic memw;
    logic mem2r;
    logic alusrc;
    logic extop;
    logic branch;
    logic bne;
    logic jump;
    logic jr;
    logic link;
    logic illegal;
  } ctrl_t;

  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn >= FN_MULT) && (fn <= FN_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_decode : combinational opcode/funct to control-bundle decoder    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module ctrl_decode
  import ctrl_defs_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       rd_zero,
  output ctrl_t      ctl,
  output wr_sel_e    wr_sel,
  output logic [5:0] aluctrl,
  output logic       uses_rt
);

  always_comb begin
    ctl       = '0;
    ctl.valid = 1'b1;
    wr_sel    = WR_NONE;
    aluctrl   = '0;
    uses_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        aluctrl = funct;
        if (funct == FN_JR) begin
          ctl.jr   = 1'b1;
          ctl.jump = 1'b1;
        end else if (!(funct == FN_SLL && rd_zero)) begin
          ctl.regw = 1'b1;
          wr_sel   = WR_RD;
        end
      end
      OP_J: ctl.jump = 1'b1;
      OP_JAL: begin
        ctl.jump = 1'b1;
        ctl.link = 1'b1;
        ctl.regw = 1'b1;
        wr_sel   = WR_R31;
      end
      OP_BEQ, OP_BNE: begin
        ctl.branch = 1'b1;
        ctl.bne    = opcode[0];
        ctl.extop  = 1'b1;
        aluctrl    = ALU_SUB;
        uses_rt    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ctl.alusrc = 1'b1;
        ctl.extop  = 1'b1;
        ctl.regw   = 1'b1;
        wr_sel     = WR_RT;
        aluctrl    = opcode;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctl.alusrc = 1'b1;
        ctl.regw   = 1'b1;
        wr_sel     = WR_RT;
        aluctrl    = opcode;
      end
      OP_LW: begin
        ctl.memr   = 1'b1;
        ctl.mem2r  = 1'b1;
        ctl.alusrc = 1'b1;
        ctl.extop  = 1'b1;
        ctl.regw   = 1'b1;
        wr_sel     = WR_RT;
        aluctrl    = ALU_ADD;
      end
      OP_SW: begin
        ctl.memw   = 1'b1;
        ctl.alusrc = 1'b1;
        ctl.extop  = 1'b1;
        aluctrl    = ALU_ADD;
        uses_rt    = 1'b1;
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_unit : registered ID/EX control with load-use, flush and    |
// |                  optional mul/div stall (PIPE_CTRL_MULDIV_STALL_EN)   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module pipe_ctrl_unit
  import ctrl_defs_pkg::*;
#(
  parameter int ALU_W  = 6,
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_regw,
  output logic             ex_memr,
  output logic             ex_memw,
  output logic             ex_mem2r,
  output logic             ex_alusrc,
  output logic             ex_extop,
  output logic             ex_branch,
  output logic             ex_bne,
  output logic             ex_jump,
  output logic             ex_jr,
  output logic             ex_link,
  output logic [ALU_W-1:0] ex_aluctrl,
  output logic [RA_W-1:0]  ex_wr_reg,
  output logic             ex_illegal,
  output logic             md_busy
);

  ctrl_t            w_dec;
  wr_sel_e          w_sel;
  logic [5:0]       w_alu;
  logic             w_uses_rt;
  logic [RA_W-1:0]  w_dst;
  logic             w_hazard;
  logic             w_md_stall;
  logic             w_load;

  ctrl_t            r_ctl;
  logic [ALU_W-1:0] r_aluctrl;
  logic [RA_W-1:0]  r_wr_reg;

  ctrl_decode u_decode (
    .opcode  (id_opcode),
    .funct   (id_funct),
    .rd_zero (id_rd == '0),
    .ctl     (w_dec),
    .wr_sel  (w_sel),
    .aluctrl (w_alu),
    .uses_rt (w_uses_rt)
  );

  always_comb begin
    w_dst = '0;
    if (w_dec.regw) begin
      case (w_sel)
        WR_RT:   w_dst = id_rt;
        WR_RD:   w_dst = id_rd;
        WR_R31:  w_dst = RA_W'(31);
        default: w_dst = '0;
      endcase
    end
  end

  assign w_hazard = r_ctl.valid && r_ctl.memr && (r_wr_reg != '0) && id_valid &&
                    ((r_wr_reg == id_rs) || ((r_wr_reg == id_rt) && w_uses_rt));

`ifdef PIPE_CTRL_MULDIV_STALL_EN
  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  logic [MD_W-1:0] r_md_cnt;

  assign w_md_stall = (r_md_cnt != '0);
  assign md_busy    = w_md_stall;

  // Counter holds the remaining busy cycles after the mul/div enters EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (ex_flush) begin
      r_md_cnt <= '0;
    end else if (w_md_stall) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end else if (w_load && is_muldiv(id_opcode, id_funct)) begin
      r_md_cnt <= MD_W'(MD_LAT - 1);
    end
  end
`else
  assign w_md_stall = 1'b0;
  assign md_busy    = 1'b0;
`endif

  assign stall  = !ex_flush && (w_md_stall || w_hazard);
  assign w_load = id_valid && !ex_flush && !w_md_stall && !w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl     <= '0;
      r_aluctrl <= '0;
      r_wr_reg  <= '0;
    end else if (w_load) begin
      r_ctl     <= w_dec;
      r_aluctrl <= ALU_W'(w_alu);
      r_wr_reg  <= w_dst;
    end else begin
      r_ctl     <= '0;
      r_aluctrl <= '0;
      r_wr_reg  <= '0;
    end
  end

  assign ex_valid   = r_ctl.valid;
  assign ex_regw    = r_ctl.regw;
  assign ex_memr    = r_ctl.memr;
  assign ex_memw    = r_ctl.memw;
  assign ex_mem2r   = r_ctl.mem2r;
  assign ex_alusrc  = r_ctl.alusrc;
  assign ex_extop   = r_ctl.extop;
  assign ex_branch  = r_ctl.branch;
  assign ex_bne     = r_ctl.bne;
  assign ex_jump    = r_ctl.jump;
  assign ex_jr      = r_ctl.jr;
  assign ex_link    = r_ctl.link;
  assign ex_illegal = r_ctl.illegal;
  assign ex_aluctrl = r_aluctrl;
  assign ex_wr_reg  = r_wr_reg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_ctrl_unit : directed self-checking bench for pipe_ctrl_unit   |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_flush;
  logic       stall;
  logic       ex_valid, ex_regw, ex_memr, ex_memw, ex_mem2r, ex_alusrc, ex_extop;
  logic       ex_branch, ex_bne, ex_jump, ex_jr, ex_link, ex_illegal, md_busy;
  logic [5:0] ex_aluctrl;
  logic [4:0] ex_wr_reg;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl_unit #(.ALU_W(6), .RA_W(5), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_regw(ex_regw),
    .ex_memr(ex_memr), .ex_memw(ex_memw), .ex_mem2r(ex_mem2r),
    .ex_alusrc(ex_alusrc), .ex_extop(ex_extop), .ex_branch(ex_branch),
    .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_link(ex_link),
    .ex_aluctrl(ex_aluctrl), .ex_wr_reg(ex_wr_reg), .ex_illegal(ex_illegal),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_stall;
    rst_n    = 1'b0;
    ex_flush = 1'b0;
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_regw", ex_regw, 0);
    chk("rst_alu", ex_aluctrl, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mdbusy", md_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // lw $5 then addu $7,$5,$2: one-cycle load-use stall
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    chk("lw_stall", stall, 0);
    step();
    chk("lw_memr", ex_memr, 1);
    chk("lw_mem2r", ex_mem2r, 1);
    chk("lw_wr", ex_wr_reg, 5);
    chk("lw_alu", ex_aluctrl, 6'h20);
    set_id(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd7);
    chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_regw", ex_regw, 0);
    chk("lu_stall_end", stall, 0);
    step();
    chk("addu_valid", ex_valid, 1);
    chk("addu_alu", ex_aluctrl, 6'h21);
    chk("addu_wr", ex_wr_reg, 7);
    chk("addu_regw", ex_regw, 1);

    // lw writing $0 followed by reader of $0
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
    step();
    set_id(1'b1, 6'h00, 6'h21, 5'd0, 5'd0, 5'd3);
    chk("lw0_stall", stall, 0);
    step();

    // lw $5 then addi with rt=5 as destination only
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, 6'h08, 6'h00, 5'd3, 5'd5, 5'd0);
    chk("addi_rt_stall", stall, 0);
    step();
    chk("addi_alu", ex_aluctrl, 6'h08);
    chk("addi_extop", ex_extop, 1);
    chk("addi_wr", ex_wr_reg, 5);

    // beq reads rt: hazard on rt
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd6, 5'd0);
    step();
    set_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd6, 5'd0);
    chk("beq_rt_stall", stall, 1);
    step();
    step();
    chk("beq_branch", ex_branch, 1);
    chk("beq_bne", ex_bne, 0);
    chk("beq_alu", ex_aluctrl, 6'h22);

    // flush in the same cycle as a load-use hazard
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd7);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    step();
    ex_flush = 1'b0;
    chk("flush_valid", ex_valid, 0);

    // decode sweep
    set_id(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("jal_link", ex_link, 1);
    chk("jal_jump", ex_jump, 1);
    chk("jal_regw", ex_regw, 1);
    chk("jal_wr", ex_wr_reg, 31);
    set_id(1'b1, 6'h0D, 6'h00, 5'd2, 5'd9, 5'd0);
    step();
    chk("ori_extop", ex_extop, 0);
    chk("ori_alu", ex_aluctrl, 6'h0D);
    chk("ori_alusrc", ex_alusrc, 1);
    chk("ori_wr", ex_wr_reg, 9);
    set_id(1'b1, 6'h2B, 6'h00, 5'd2, 5'd4, 5'd0);
    step();
    chk("sw_regw", ex_regw, 0);
    chk("sw_wr", ex_wr_reg, 0);
    chk("sw_memw", ex_memw, 1);
    chk("sw_alu", ex_aluctrl, 6'h20);
    set_id(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    step();
    chk("ill_flag", ex_illegal, 1);
    chk("ill_valid", ex_valid, 1);
    chk("ill_regw", ex_regw, 0);
    set_id(1'b1, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("nop_ill_clear", ex_illegal, 0);
    chk("nop_regw", ex_regw, 0);
    chk("nop_valid", ex_valid, 1);
    set_id(1'b1, 6'h05, 6'h00, 5'd1, 5'd2, 5'd0);
    step();
    chk("bne_bne", ex_bne, 1);
    chk("bne_extop", ex_extop, 1);
    set_id(1'b1, 6'h00, 6'h08, 5'd31, 5'd0, 5'd0);
    step();
    chk("jr_jr", ex_jr, 1);
    chk("jr_jump", ex_jump, 1);
    chk("jr_regw", ex_regw, 0);
    set_id(1'b1, 6'h0F, 6'h00, 5'd0, 5'd8, 5'd0);
    step();
    chk("lui_alu", ex_aluctrl, 6'h0F);
    chk("lui_extop", ex_extop, 0);
    chk("lui_wr", ex_wr_reg, 8);
    set_id(1'b0, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
    chk("novalid_stall", stall, 0);
    step();
    chk("novalid_bubble", ex_valid, 0);

`ifdef PIPE_CTRL_MULDIV_STALL_EN
    // mult then addu: three stall cycles
    set_id(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
    chk("mult_stall", stall, 0);
    step();
    chk("mult_alu", ex_aluctrl, 6'h18);
    set_id(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd10);
    n_stall = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall) n_stall++;
      if (md_busy && !stall) n_stall += 100;
      step();
    end
    chk("md_stall_cycles", n_stall, 3);
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    step();
    // flush in the second busy cycle clears the counter
    set_id(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
    step();
    set_id(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd10);
    chk("md_c1_stall", stall, 1);
    chk("md_c1_busy", md_busy, 1);
    step();
    chk("md_c2_busy", md_busy, 1);
    ex_flush = 1'b1;
    #1;
    chk("md_flush_stall", stall, 0);
    step();
    ex_flush = 1'b0;
    #1;
    chk("md_flush_busy", md_busy, 0);
    chk("md_flush_stall_after", stall, 0);
    chk("md_flush_valid", ex_valid, 0);
    step();
    chk("md_addu_alu", ex_aluctrl, 6'h21);
`else
    // mult is a plain R-type without the mul/div feature
    set_id(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
    step();
    chk("mult_alu", ex_aluctrl, 6'h18);
    chk("mult_busy", md_busy, 0);
    set_id(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd10);
    n_stall = 0;
    chk("mult_nostall", stall, 0);
    step();
    chk("mult_next_alu", ex_aluctrl, 6'h21);
`endif

    // asynchronous reset mid-cycle while ex_regw=1
    set_id(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
    step();
    chk("pre_rst_regw", ex_regw, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_regw", ex_regw, 0);
    chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_wr", ex_wr_reg, 0);
    chk("async_rst_alu", ex_aluctrl, 0);
    chk("async_rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered successor to the combinational main decoder for the 5-stage MIPS pipeline. It decodes the ID-stage opcode/funct into a control bundle and holds that bundle in the ID/EX control register. It also detects load-use hazards, applies branch/jump flushes by inserting bubbles, and drives the stall line to PC and IF/ID. The ALU-control width and register-address width are parametrised.

Parameters:
ALU_W, 6, width of ALU control code (must be >= 6; codes are zero-extended)
RA_W, 5, register address width
MD_LAT, 4, multiply/divide occupancy in cycles (used only with the optional feature; must be >= 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  6  instruction[31:26]
id_funct  in  6  instruction[5:0]
id_rs  in  RA_W  source register 1
id_rt  in  RA_W  source register 2 / I-type destination
id_rd  in  RA_W  R-type destination
ex_flush  in  1  branch/jump resolved taken in EX; kill the ID instruction
stall  out  1  hold PC and IF/ID (combinational from registered state plus ID inputs)
ex_valid, ex_regw, ex_memr, ex_memw, ex_mem2r, ex_alusrc, ex_extop, ex_branch, ex_bne, ex_jump, ex_jr, ex_link  out  1 each  registered control bundle
ex_aluctrl  out  ALU_W  registered ALU operation code
ex_wr_reg  out  RA_W  registered destination register
ex_illegal  out  1  registered; 1 for one EX cycle when an undefined opcode/funct was accepted
md_busy  out  1  multiply/divide counter active (tied 0 when the optional feature is absent)

Behaviour:
- Reset (async, rst_n=0): every ex_* output = 0, md counter = 0. Because stall depends only on registered state and the ID inputs, stall = 0 during reset.
- Latency: one edge. Decode of the ID inputs appears on ex_* after the next rising clk.
- Decode (ExtOp 1 = sign-extend):
  - op 00 R-type: regw, RegDst to rd, aluctrl = funct. funct 00 with rd=0 is a NOP with regw=0. funct 08 (jr): jr=1, jump=1, regw=0.
  - op 02 j: jump=1. op 03 jal: jump=1, link=1, regw=1, wr_reg=31.
  - op 04 beq / 05 bne: branch=1, bne=op[0], extop=1, aluctrl=22.
  - op 08, 09, 0A: alusrc=1, extop=1, regw=1, wr_reg=rt, aluctrl=op.
  - op 0C, 0D, 0E: the same but extop=0. op 0F (lui): alusrc=1, regw=1, aluctrl=0F.
  - op 23 lw: memr, mem2r, alusrc, extop, regw, wr_reg=rt, aluctrl=20.
  - op 2B sw: memw, alusrc, extop, aluctrl=20, regw=0.
  - Any other opcode: illegal=1, all write/branch/jump signals 0, valid=1.
- wr_reg is forced to 0 whenever regw=0.
- Load-use hazard: condition = ex_valid & ex_memr & ex_wr_reg!=0 & id_valid & (ex_wr_reg==id_rs | (ex_wr_reg==id_rt & uses_rt)). uses_rt applies to R-type, beq, bne and sw. When the condition holds: stall=1 and ID/EX loads a bubble (all ex_* = 0). Because EX then holds a bubble, stall lasts exactly one cycle.
- Flush: ex_flush=1 makes ID/EX load a bubble and forces stall=0. Flush overrides hazard and md stall in the same cycle.
- id_valid=0 with no flush: ID/EX loads a bubble and stall=0.
- Priority, highest first: rst_n, ex_flush, md stall, load-use stall, normal load.

Optional Feature:
PIPE_CTRL_MULDIV_STALL_EN
- Defined:
  - An R-type instruction with funct 18–1B is accepted normally, and the md counter loads MD_LAT-1.
  - While the counter is nonzero: md_busy=1, stall=1, ID/EX loads bubbles, and the counter decrements each cycle.
  - ex_flush clears the counter.
  - With MD_LAT=1 there is no extra stall.
- Undefined: funct 18–1B decode as plain R-type with no extra stall, the counter logic is absent, and md_busy is tied 0.

Decomposition:
- Shared package/include ctrl_defs: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI..OP_LUI, OP_LW, OP_SW), funct constants (FN_JR, FN_MULT..FN_DIVU), ALU codes (ALU_ADD=20, ALU_SUB=22), and the control-bundle field ordering.
- One combinational sub-module, ctrl_decode (opcode/funct → bundle plus uses_rt), reused by any later decoder.
- Hazard logic, flush handling, md counter and the ID/EX register stay in pipe_ctrl_unit.

Test Plan:
- Reset sequence: drive rst_n low mid-cycle while ex_regw=1 → all ex_* = 0 immediately, stall=0.
- Load-use: lw with rt=5, then addu with rs=5 → stall=1 for exactly one cycle and a bubble in EX. Then addu reaches EX with aluctrl=21 and wr_reg=rd.
- Load-use exemption: lw writing $0 followed by a reader of $0, and lw rt=5 followed by addi reading rt=5 as its destination → stall=0 in both cases.
- Flush priority: ex_flush=1 in the same cycle as a load-use hazard → stall=0 and the next ex_valid=0.
- Decode sweep: jal → link=1, wr_reg=31, regw=1. ori → extop=0, aluctrl=0D. sw → regw=0, wr_reg=0, aluctrl=20. opcode 3F → ex_illegal=1 for one cycle.
- With PIPE_CTRL_MULDIV_STALL_EN and MD_LAT=4: mult, then addu → stall high for 3 cycles and md_busy high for 3 cycles. ex_flush asserted during the second of those cycles clears the counter at once.
